cv32e41s_lsu_txn_tracker: RTL and testbench
===========================================

Name: cv32e41s_lsu_txn_tracker

Overview:
- Initiator-side counterpart of the watchpoint/MPU transaction filter on the data path. It sits between the LSU and the WPT stage.
- Issues LSU requests only when downstream response storage is guaranteed. Counts outstanding transactions and produces the one-pending-next-cycle indication the WPT stage consumes.
- Buffers returning responses (bus status, MPU status, watchpoint match) in a FIFO so the LSU may stall. Accumulates watchpoint hits into a sticky register.

Parameters:
DEPTH, 2, max outstanding transactions plus buffered responses; legal range 1..7.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
lsu_trans_valid_i  input  1  LSU request valid
lsu_trans_ready_o  output  1  request accepted
lsu_trans_pushpop_i  input  1  request belongs to push/pop sequence
lsu_trans_i  input  obi_data_req_t  request payload
wpt_trans_valid_o  output  1  request towards WPT stage
wpt_trans_ready_i  input  1  WPT stage accepts
wpt_trans_pushpop_o  output  1  forwarded pushpop flag
wpt_trans_o  output  obi_data_req_t  forwarded payload
wpt_resp_valid_i  input  1  response from WPT stage (cannot be stalled)
wpt_resp_i  input  data_resp_t  response payload (bus_resp, mpu_status, wpt_match)
lsu_resp_valid_o  output  1  buffered response available
lsu_resp_ready_i  input  1  LSU consumes response
lsu_resp_o  output  data_resp_t  FIFO head
one_txn_pend_n_o  output  1  exactly one transaction outstanding next cycle
outstanding_o  output  3  current outstanding count (cnt_q)
wpt_match_sticky_o  output  32  OR of wpt_match of all pushed responses
wpt_match_clear_i  input  1  clear sticky register
resp_err_o  output  1  sticky: response received with cnt_q==0

Behaviour:
- Reset: cnt_q=0, occ_q=0, FIFO pointers 0, sticky=0, resp_err_o=0. All valid outputs 0. lsu_resp_o is don't-care while invalid.
- Credit rule: credit_ok = (cnt_q + occ_q) < DEPTH.
  - wpt_trans_valid_o = lsu_trans_valid_i && credit_ok.
  - lsu_trans_ready_o = wpt_trans_ready_i && credit_ok.
  - Payload and pushpop pass through combinationally.
- accept = wpt_trans_valid_o && wpt_trans_ready_i.
- Only responses arriving with cnt_q>0 are counted and stored. A response with cnt_q==0 is dropped (no push, count unchanged) and sets resp_err_o until reset.
- Outstanding counter:
  - cnt_n = cnt_q + accept - (wpt_resp_valid_i && cnt_q>0).
  - Same-cycle accept and response leaves cnt unchanged.
  - cnt never exceeds DEPTH.
- one_txn_pend_n_o = (cnt_n == 1), combinational from this cycle's events.
- Response FIFO:
  - DEPTH entries, circular read/write pointers that wrap at DEPTH-1.
  - Push on a counted response.
  - Pop when lsu_resp_valid_o && lsu_resp_ready_i; lsu_resp_valid_o = (occ_q != 0).
  - No bypass: a response is visible to the LSU one cycle after wpt_resp_valid_i.
  - Simultaneous push and pop: occ unchanged, both pointers advance.
  - Overflow is impossible because the credit rule guarantees free space for every outstanding transaction. A push with occ_q==DEPTH is an assertion failure.
- Sticky watchpoint register:
  - sticky_n = (clear ? 0 : sticky_q) | (push ? wpt_resp_i.wpt_match : 0).
  - A push in the same cycle as a clear therefore survives the clear.
- Ordering: responses are delivered in arrival order. No reordering or filtering of watchpoint-consumed responses; they are ordinary FIFO entries.
- Reset asserted mid-operation clears all state. In-flight responses arriving after reset count as errors.

Test Plan:
- DEPTH=2, LSU ready held 0; issue 3 back-to-back requests with wpt_trans_ready_i=1. Required: first two accepted (outstanding_o 1 then 2); third held with wpt_trans_valid_o=0 until a response is popped.
- One request accepted, then response next cycle. Required: one_txn_pend_n_o=1 in the accept cycle and 0 in the response cycle; lsu_resp_valid_o rises the cycle after the response.
- Accept and response in the same cycle with cnt_q=1. Required: outstanding_o stays 1 and one_txn_pend_n_o=1.
- Responses with wpt_match 0x1 then 0x4. Required: wpt_match_sticky_o=0x5. Clear asserted together with a push of 0x2. Required: 0x2.
- wpt_resp_valid_i pulsed with cnt_q=0. Required: resp_err_o=1, lsu_resp_valid_o stays 0, outstanding_o stays 0.
- FIFO wrap: 6 request/response pairs with lsu_resp_ready_i toggling each cycle. Required: responses emerge in order with payloads intact across pointer wrap; credit never exceeded.

Source files
------------

// File: rtl/cv32e41s_lsu_txn_tracker.sv
// LSU-side transaction tracker: issues requests only when response storage is guaranteed,
// buffers WPT-stage responses in a FIFO and accumulates watchpoint hits.

package cv32e41s_lsu_txn_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_data_resp_t;

  typedef struct packed {
    obi_data_resp_t bus_resp;
    logic [1:0]     mpu_status;
    logic [31:0]    wpt_match;
  } data_resp_t;
endpackage

module cv32e41s_lsu_txn_tracker
  import cv32e41s_lsu_txn_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lsu_trans_valid_i,
  output logic          lsu_trans_ready_o,
  input  logic          lsu_trans_pushpop_i,
  input  obi_data_req_t lsu_trans_i,
  output logic          wpt_trans_valid_o,
  input  logic          wpt_trans_ready_i,
  output logic          wpt_trans_pushpop_o,
  output obi_data_req_t wpt_trans_o,
  input  logic          wpt_resp_valid_i,
  input  data_resp_t    wpt_resp_i,
  output logic          lsu_resp_valid_o,
  input  logic          lsu_resp_ready_i,
  output data_resp_t    lsu_resp_o,
  output logic          one_txn_pend_n_o,
  output logic [2:0]    outstanding_o,
  output logic [31:0]   wpt_match_sticky_o,
  input  logic          wpt_match_clear_i,
  output logic          resp_err_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]    cnt_q, cnt_d, occ_q, occ_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  data_resp_t    fifo_q [DEPTH];
  data_resp_t    fifo_d [DEPTH];
  logic [31:0]   sticky_q, sticky_d;
  logic          err_q, err_d;
  logic          credit_ok_s, accept_s, push_s, pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? {PW{1'b0}} : ptr + PW'(1);
  endfunction

  // Next-state logic: credit check, counters, FIFO pointers/storage, sticky flags
  always_comb begin
    // Outstanding requests and buffered responses share the same DEPTH slots
    credit_ok_s = ({1'b0, cnt_q} + {1'b0, occ_q}) < 4'(DEPTH);
    accept_s    = lsu_trans_valid_i && credit_ok_s && wpt_trans_ready_i;
    push_s      = wpt_resp_valid_i && (cnt_q != 3'd0);
    pop_s       = (occ_q != 3'd0) && lsu_resp_ready_i;

    cnt_d  = cnt_q + {2'b00, accept_s} - {2'b00, push_s};
    occ_d  = occ_q + {2'b00, push_s} - {2'b00, pop_s};
    wptr_d = push_s ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop_s ? ptr_inc(rptr_q) : rptr_q;

    fifo_d = fifo_q;
    if (push_s) begin
      fifo_d[wptr_q] = wpt_resp_i;
    end else begin
      fifo_d[wptr_q] = fifo_q[wptr_q];
    end

    // A push in the same cycle as a clear survives the clear
    sticky_d = (wpt_match_clear_i ? 32'h0000_0000 : sticky_q)
             | (push_s ? wpt_resp_i.wpt_match : 32'h0000_0000);
    err_d    = err_q || (wpt_resp_valid_i && (cnt_q == 3'd0));
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 3'd0;
      occ_q    <= 3'd0;
      wptr_q   <= {PW{1'b0}};
      rptr_q   <= {PW{1'b0}};
      sticky_q <= 32'h0000_0000;
      err_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
      fifo_q   <= fifo_d;
    end
  end

  assign wpt_trans_valid_o   = lsu_trans_valid_i && credit_ok_s;
  assign lsu_trans_ready_o   = wpt_trans_ready_i && credit_ok_s;
  assign wpt_trans_pushpop_o = lsu_trans_pushpop_i;
  assign wpt_trans_o         = lsu_trans_i;
  assign lsu_resp_valid_o    = (occ_q != 3'd0);
  assign lsu_resp_o          = fifo_q[rptr_q];
  assign one_txn_pend_n_o    = (cnt_d == 3'd1);
  assign outstanding_o       = cnt_q;
  assign wpt_match_sticky_o  = sticky_q;
  assign resp_err_o          = err_q;

endmodule

// Checker: a counted response must always find a free FIFO slot
module cv32e41s_lsu_txn_tracker_sva #(
  parameter int unsigned DEPTH = 2
) (
  input logic       clk,
  input logic       rst_n,
  input logic       push_i,
  input logic [2:0] occ_i
);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && (occ_i == 3'(DEPTH))));
endmodule

// File: tb/tb_cv32e41s_lsu_txn_tracker.sv
// Randomized + directed bench for cv32e41s_lsu_txn_tracker against a queue-based reference model.

module tb_cv32e41s_lsu_txn_tracker;
  import cv32e41s_lsu_txn_pkg::*;

  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lsu_trans_valid_i, lsu_trans_ready_o, lsu_trans_pushpop_i;
  obi_data_req_t lsu_trans_i, wpt_trans_o;
  logic          wpt_trans_valid_o, wpt_trans_ready_i, wpt_trans_pushpop_o;
  logic          wpt_resp_valid_i;
  data_resp_t    wpt_resp_i, lsu_resp_o;
  logic          lsu_resp_valid_o, lsu_resp_ready_i;
  logic          one_txn_pend_n_o;
  logic [2:0]    outstanding_o;
  logic [31:0]   wpt_match_sticky_o;
  logic          wpt_match_clear_i, resp_err_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_cnt;
  data_resp_t  m_q[$];
  logic [31:0] m_sticky;
  logic        m_err;

  logic obs_wvalid, obs_pend;
  logic toggle;

  always #5 clk = ~clk;

  cv32e41s_lsu_txn_tracker #(.DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .lsu_trans_valid_i   (lsu_trans_valid_i),
    .lsu_trans_ready_o   (lsu_trans_ready_o),
    .lsu_trans_pushpop_i (lsu_trans_pushpop_i),
    .lsu_trans_i         (lsu_trans_i),
    .wpt_trans_valid_o   (wpt_trans_valid_o),
    .wpt_trans_ready_i   (wpt_trans_ready_i),
    .wpt_trans_pushpop_o (wpt_trans_pushpop_o),
    .wpt_trans_o         (wpt_trans_o),
    .wpt_resp_valid_i    (wpt_resp_valid_i),
    .wpt_resp_i          (wpt_resp_i),
    .lsu_resp_valid_o    (lsu_resp_valid_o),
    .lsu_resp_ready_i    (lsu_resp_ready_i),
    .lsu_resp_o          (lsu_resp_o),
    .one_txn_pend_n_o    (one_txn_pend_n_o),
    .outstanding_o       (outstanding_o),
    .wpt_match_sticky_o  (wpt_match_sticky_o),
    .wpt_match_clear_i   (wpt_match_clear_i),
    .resp_err_o          (resp_err_o)
  );

  cv32e41s_lsu_txn_tracker_sva #(.DEPTH(DEPTH)) u_sva (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (dut.push_s),
    .occ_i  (dut.occ_q)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic data_resp_t mk_resp(input logic [31:0] match);
    data_resp_t r;
    r.bus_resp.rdata = $urandom;
    r.bus_resp.err   = 1'($urandom_range(0, 1));
    r.mpu_status     = 2'($urandom_range(0, 3));
    r.wpt_match      = match;
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_q.delete();
    m_sticky = 32'h0;
    m_err = 1'b0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model
  task automatic step(input logic v, input logic pp, input logic wr, input logic rv,
                      input data_resp_t rsp, input logic lr, input logic clr);
    obi_data_req_t rq;
    logic cred, acc, counted;
    int   cnt_n;
    @(negedge clk);
    rq.addr  = $urandom;
    rq.we    = 1'($urandom_range(0, 1));
    rq.be    = 4'($urandom_range(0, 15));
    rq.wdata = $urandom;
    lsu_trans_valid_i   = v;
    lsu_trans_pushpop_i = pp;
    lsu_trans_i         = rq;
    wpt_trans_ready_i   = wr;
    wpt_resp_valid_i    = rv;
    wpt_resp_i          = rsp;
    lsu_resp_ready_i    = lr;
    wpt_match_clear_i   = clr;
    #1;
    cred    = (m_cnt + m_q.size()) < DEPTH;
    acc     = v && wr && cred;
    counted = rv && (m_cnt > 0);
    cnt_n   = m_cnt + int'(acc) - int'(counted);
    check_eq("wpt_valid", wpt_trans_valid_o, v && cred);
    check_eq("lsu_ready", lsu_trans_ready_o, wr && cred);
    check_eq("pushpop", wpt_trans_pushpop_o, pp);
    check_eq("payload", wpt_trans_o, rq);
    check_eq("outstanding", outstanding_o, 3'(m_cnt));
    check_eq("resp_valid", lsu_resp_valid_o, m_q.size() != 0);
    if (m_q.size() != 0) check_eq("resp_data", lsu_resp_o, m_q[0]);
    check_eq("sticky", wpt_match_sticky_o, m_sticky);
    check_eq("resp_err", resp_err_o, m_err);
    check_eq("one_pend", one_txn_pend_n_o, cnt_n == 1);
    obs_wvalid = wpt_trans_valid_o;
    obs_pend   = one_txn_pend_n_o;
    if (m_q.size() != 0 && lr) void'(m_q.pop_front());
    if (counted) m_q.push_back(rsp);
    m_sticky = (clr ? 32'h0 : m_sticky) | (counted ? rsp.wpt_match : 32'h0);
    if (rv && m_cnt == 0) m_err = 1'b1;
    m_cnt = cnt_n;
    @(posedge clk);
  endtask

  task automatic idle(input logic lr);
    step(1'b0, 1'b0, 1'b0, 1'b0, mk_resp(32'h0), lr, 1'b0);
  endtask

  task automatic rand_phase(input int n);
    logic rv;
    for (int i = 0; i < n; i++) begin
      rv = (m_cnt > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 63) == 0);
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           rv, mk_resp($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    lsu_trans_valid_i = 1'b0; lsu_trans_pushpop_i = 1'b0; lsu_trans_i = '0;
    wpt_trans_ready_i = 1'b0; wpt_resp_valid_i = 1'b0; wpt_resp_i = '0;
    lsu_resp_ready_i = 1'b0; wpt_match_clear_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outstanding", outstanding_o, 3'd0);
    check_eq("rst_resp_valid", lsu_resp_valid_o, 1'b0);
    check_eq("rst_wpt_valid", wpt_trans_valid_o, 1'b0);
    check_eq("rst_sticky", wpt_match_sticky_o, 32'h0);
    check_eq("rst_err", resp_err_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Credit limit: two accepted, third held until a response is popped
    step(1'b1, 1'b0, 1'b1, 1'b0, mk_resp(32'h0), 1'b0, 1'b0);
    #1 check_eq("credit_out1", outstanding_o, 3'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, mk_resp(32'h0), 1'b0, 1'b0);
    #1 check_eq("credit_out2", outstanding_o, 3'd2);
    step(1'b1, 1'b0, 1'b1, 1'b0, mk_resp(32'h0), 1'b0, 1'b0);
    check_eq("credit_block_full", obs_wvalid, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, mk_resp(32'h0), 1'b0, 1'b0);
    check_eq("credit_block_buffered", obs_wvalid, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, mk_resp(32'h0), 1'b1, 1'b0);
    check_eq("credit_block_popping", obs_wvalid, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, mk_resp(32'h0), 1'b0, 1'b0);
    check_eq("credit_release", obs_wvalid, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk_resp(32'h0), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk_resp(32'h0), 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // Single transaction: pend flag and one-cycle response latency
    step(1'b1, 1'b0, 1'b1, 1'b0, mk_resp(32'h0), 1'b1, 1'b0);
    check_eq("single_pend_accept", obs_pend, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk_resp(32'h0), 1'b0, 1'b0);
    check_eq("single_pend_resp", obs_pend, 1'b0);
    #1 check_eq("single_resp_visible", lsu_resp_valid_o, 1'b1);
    repeat (2) idle(1'b1);

    // Accept and response in the same cycle with one outstanding
    step(1'b1, 1'b0, 1'b1, 1'b0, mk_resp(32'h0), 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, mk_resp(32'h0), 1'b1, 1'b0);
    check_eq("same_cycle_pend", obs_pend, 1'b1);
    #1 check_eq("same_cycle_out", outstanding_o, 3'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk_resp(32'h0), 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // Sticky watchpoint accumulation and clear-vs-push priority
    step(1'b1, 1'b0, 1'b1, 1'b0, mk_resp(32'h0), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk_resp(32'h1), 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, mk_resp(32'h0), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk_resp(32'h4), 1'b1, 1'b0);
    #1 check_eq("sticky_or", wpt_match_sticky_o, 32'h5);
    step(1'b1, 1'b0, 1'b1, 1'b0, mk_resp(32'h0), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk_resp(32'h2), 1'b1, 1'b1);
    #1 check_eq("sticky_clear_push", wpt_match_sticky_o, 32'h2);
    repeat (2) idle(1'b1);

    // FIFO wrap with toggling LSU ready
    toggle = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, mk_resp(32'h0), toggle, 1'b0);
      toggle = ~toggle;
      step(1'b0, 1'b0, 1'b0, m_cnt > 0, mk_resp($urandom), toggle, 1'b0);
      toggle = ~toggle;
    end
    repeat (4) idle(1'b1);

    // Spurious response with nothing outstanding
    step(1'b0, 1'b0, 1'b0, 1'b1, mk_resp(32'h8), 1'b0, 1'b0);
    #1;
    check_eq("spurious_err", resp_err_o, 1'b1);
    check_eq("spurious_no_resp", lsu_resp_valid_o, 1'b0);
    check_eq("spurious_out", outstanding_o, 3'd0);

    rand_phase(800);

    // Asynchronous reset mid-operation, then an in-flight response arrives
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("midrst_outstanding", outstanding_o, 3'd0);
    check_eq("midrst_resp_valid", lsu_resp_valid_o, 1'b0);
    check_eq("midrst_sticky", wpt_match_sticky_o, 32'h0);
    check_eq("midrst_err", resp_err_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, mk_resp(32'h10), 1'b1, 1'b0);
    #1 check_eq("post_rst_err", resp_err_o, 1'b1);

    rand_phase(800);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
